// File: rtl/axis_packet_tx_if.sv
// AXI4-Stream channel for axis_packet_tx: the master drives every signal except tready,
// which the slave drives.
interface axis_packet_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 8
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_packet_tx.sv
// AXI4-Stream master that emits one packet of incrementing data words per start command.
// Optional macro AXIS_TX_BEAT_GAP_EN inserts one idle cycle after every accepted non-final beat.
module axis_packet_tx #(
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int DEST_WIDTH      = 4,
  parameter int USER_WIDTH      = 8,
  parameter int MAX_PACKET_SIZE = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [7:0]            pkt_len,
  input  logic [DATA_WIDTH-1:0] start_value,
  input  logic [ID_WIDTH-1:0]   stream_id,
  input  logic [DEST_WIDTH-1:0] stream_dest,
  axis_packet_tx_if.master      m_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [15:0]           pkt_count
);
  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0] MAX_LEN    = 8'(MAX_PACKET_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  handshake_s;
  logic                  load_s;
  logic                  step_s;
  logic                  finish_s;
  logic                  zero_len_s;
  logic [7:0]            len_clamp_s;
  logic [7:0]            len_r;
  logic [7:0]            beat_idx_r;
  logic                  tvalid_r;
  logic                  tlast_r;
  logic [DATA_WIDTH-1:0] tdata_r;
  logic [ID_WIDTH-1:0]   tid_r;
  logic [DEST_WIDTH-1:0] tdest_r;
  logic [USER_WIDTH-1:0] tuser_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  len_err_r;
  logic [15:0]           pkt_count_r;

  assign handshake_s = tvalid_r & m_axis.tready;
  assign len_clamp_s = (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = load_s ? ST_SEND : ST_IDLE;
      ST_SEND: begin
        if (finish_s) begin
          state_nxt_s = ST_IDLE;
        end
`ifdef AXIS_TX_BEAT_GAP_EN
        else if (step_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_SEND;
        end
`else
        else begin
          state_nxt_s = ST_SEND;
        end
`endif
      end
      ST_GAP:  state_nxt_s = ST_SEND;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Decode the per-cycle datapath actions; start is only honoured in IDLE.
  always_comb begin
    load_s     = 1'b0;
    step_s     = 1'b0;
    finish_s   = 1'b0;
    zero_len_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s     = start & (pkt_len != 8'd0);
        zero_len_s = start & (pkt_len == 8'd0);
      end
      ST_SEND: begin
        finish_s = handshake_s & tlast_r;
        step_s   = handshake_s & ~tlast_r;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // tlast for the following beat is precomputed so every stream output comes straight from a flop.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      tdata_r     <= '0;
      tid_r       <= '0;
      tdest_r     <= '0;
      tuser_r     <= '0;
      len_r       <= 8'd0;
      beat_idx_r  <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      len_err_r   <= 1'b0;
      pkt_count_r <= 16'd0;
    end else begin
      tvalid_r  <= (state_nxt_s == ST_SEND);
      busy_r    <= (state_nxt_s != ST_IDLE);
      done_r    <= finish_s;
      len_err_r <= zero_len_s;
      if (finish_s) begin
        pkt_count_r <= pkt_count_r + 16'd1;
      end
      if (load_s) begin
        tdata_r    <= start_value;
        tid_r      <= stream_id;
        tdest_r    <= stream_dest;
        tuser_r    <= '0;
        len_r      <= len_clamp_s;
        beat_idx_r <= 8'd0;
        tlast_r    <= (len_clamp_s == 8'd1);
      end else if (step_s) begin
        tdata_r    <= tdata_r + DATA_WIDTH'(1);
        tuser_r    <= USER_WIDTH'(beat_idx_r + 8'd1);
        beat_idx_r <= beat_idx_r + 8'd1;
        tlast_r    <= (({1'b0, beat_idx_r} + 9'd2) == {1'b0, len_r});
      end else if (finish_s) begin
        tlast_r <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tdata  = tdata_r;
  assign m_axis.tstrb  = {STRB_WIDTH{1'b1}};
  assign m_axis.tkeep  = {STRB_WIDTH{1'b1}};
  assign m_axis.tlast  = tlast_r;
  assign m_axis.tid    = tid_r;
  assign m_axis.tdest  = tdest_r;
  assign m_axis.tuser  = tuser_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign len_err       = len_err_r;
  assign pkt_count     = pkt_count_r;
endmodule

// File: tb/tb_axis_packet_tx.sv
// Scoreboard bench for axis_packet_tx: a packet-level model queues expected beats and a
// negedge monitor checks every handshake, stall stability, done and pkt_count.
module tb_axis_packet_tx;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [7:0]  pkt_len;
  logic [31:0] start_value;
  logic [7:0]  stream_id;
  logic [3:0]  stream_dest;
  logic        busy, done, len_err;
  logic [15:0] pkt_count;

  axis_packet_tx_if #(.DATA_WIDTH(32), .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(8)) axis ();

  axis_packet_tx dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .pkt_len(pkt_len),
    .start_value(start_value), .stream_id(stream_id), .stream_dest(stream_dest),
    .m_axis(axis), .busy(busy), .done(done), .len_err(len_err), .pkt_count(pkt_count)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  id;
    logic [3:0]  dest;
    logic [7:0]  user;
    int          pkt_no;
  } beat_t;

  beat_t       sb[$];
  int          tests = 0;
  int          fails = 0;
  int          model_pkts = 0;
  int          hs_count = 0;
  int          pend_count = 0;
  bit          pend_done = 1'b0;
  bit          stall_hold = 1'b0;
  bit          rmode = 1'b0;
  logic [63:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one start expands to min(len, 10) beats of start_value + i.
  task automatic model_push(input logic [7:0] len, input logic [31:0] sv,
                            input logic [7:0] id, input logic [3:0] dest);
    int    eff;
    beat_t b;
    eff = (len > 8'd10) ? 10 : int'(len);
    if (eff > 0) model_pkts++;
    for (int i = 0; i < eff; i++) begin
      b.data   = sv + 32'(i);
      b.last   = (i == eff - 1);
      b.id     = id;
      b.dest   = dest;
      b.user   = 8'(i);
      b.pkt_no = model_pkts;
      sb.push_back(b);
    end
  endtask

  // Monitor: sampled on the falling edge, i.e. before the rising edge that completes a handshake.
  always @(negedge ACLK) begin
    if (ARESET) begin
      pend_done  = 1'b0;
      stall_hold = 1'b0;
    end else begin
      if (pend_done || done) begin
        chk("done_after_last", 64'(done), 64'(pend_done));
        if (pend_done) chk("pkt_count_at_done", 64'(pkt_count), 64'(pend_count));
      end
      pend_done = 1'b0;
      if (stall_hold)
        chk("stall_stable", {11'd0, axis.tvalid, axis.tdata, axis.tlast, axis.tid, axis.tdest, axis.tuser},
            {11'd0, 1'b1, held[52:0]});
      if (axis.tvalid && axis.tready) begin
        stall_hold = 1'b0;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: tdata=%0h tuser=%0h with empty queue", axis.tdata, axis.tuser);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("tdata", 64'(axis.tdata), 64'(e.data));
          chk("tlast", 64'(axis.tlast), 64'(e.last));
          chk("tid",   64'(axis.tid),   64'(e.id));
          chk("tdest", 64'(axis.tdest), 64'(e.dest));
          chk("tuser", 64'(axis.tuser), 64'(e.user));
          chk("tstrb_tkeep", {56'd0, axis.tstrb, axis.tkeep}, 64'hFF);
          hs_count++;
          if (e.last) begin
            pend_done  = 1'b1;
            pend_count = e.pkt_no;
          end
        end
      end else if (axis.tvalid) begin
        stall_hold = 1'b1;
        held = {11'd0, axis.tdata, axis.tlast, axis.tid, axis.tdest, axis.tuser};
      end else begin
        stall_hold = 1'b0;
      end
    end
  end

  // Sink ready: always high or pseudo-random per cycle.
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      axis.tready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  // Called at posedge+1 with the DUT idle; checks the one-cycle start latency or the len_err pulse.
  task automatic issue(input logic [7:0] len, input logic [31:0] sv,
                       input logic [7:0] id, input logic [3:0] dest);
    start = 1'b1; pkt_len = len; start_value = sv; stream_id = id; stream_dest = dest;
    model_push(len, sv, id, dest);
    cyc();
    start = 1'b0;
    if (len == 8'd0) begin
      chk("len_err_pulse", 64'(len_err), 64'd1);
      chk("len0_tvalid",   64'(axis.tvalid), 64'd0);
      chk("len0_busy",     64'(busy), 64'd0);
      cyc();
      chk("len_err_one_cycle", 64'(len_err), 64'd0);
    end else begin
      chk("beat0_latency", 64'(axis.tvalid), 64'd1);
      chk("busy_on_start", 64'(busy), 64'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0 || pend_done) && n < 400) begin
      cyc();
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy=%0d queue=%0d after %0d cycles", busy, sb.size(), n);
      sb.delete();
    end
    cyc();
  endtask

  initial begin
    int n;
    ARESET = 1'b1; start = 1'b0; pkt_len = 8'd0; start_value = 32'd0;
    stream_id = 8'd0; stream_dest = 4'd0;
    repeat (3) cyc();
    chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("rst_tlast",  64'(axis.tlast), 64'd0);
    chk("rst_tdata",  64'(axis.tdata), 64'd0);
    chk("rst_tid",    64'(axis.tid), 64'd0);
    chk("rst_tdest",  64'(axis.tdest), 64'd0);
    chk("rst_tuser",  64'(axis.tuser), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    ARESET = 1'b0;
    cyc();

    // Abort mid-packet: reset while beat 3 of 8 is presented.
    issue(8'd8, 32'd100, 8'd1, 4'd2);
    n = 0;
    while (hs_count < 3 && n < 50) begin cyc(); n++; end
    chk("abort_reached_beat3", 64'(hs_count), 64'd3);
    ARESET = 1'b1;
    sb.delete();
    model_pkts = 0;
    cyc();
    chk("abort_tvalid", 64'(axis.tvalid), 64'd0);
    chk("abort_busy",   64'(busy), 64'd0);
    chk("abort_count",  64'(pkt_count), 64'd0);
    ARESET = 1'b0;
    cyc();
    chk("abort_no_done", 64'(done), 64'd0);
    repeat (3) cyc();
    chk("abort_not_resumed", 64'(axis.tvalid), 64'd0);

    // Directed packets.
    issue(8'd8, 32'd1, 8'd0, 4'd0);
    wait_idle();
    chk("count_after_first", 64'(pkt_count), 64'd1);
    rmode = 1'b1;
    issue(8'd8, 32'd1, 8'd0, 4'd0);
    wait_idle();
    issue(8'd4, 32'hFFFF_FFFE, 8'd3, 4'd5);
    wait_idle();
    issue(8'd0, 32'd7, 8'd0, 4'd0);
    wait_idle();
    issue(8'd15, 32'd20, 8'd9, 4'd1);
    wait_idle();
    issue(8'd1, 32'd55, 8'd2, 4'd3);
    wait_idle();

    // start while busy must be ignored.
    issue(8'd6, 32'd300, 8'd4, 4'd4);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; pkt_len = 8'd2; start_value = 32'd999; stream_id = 8'hEE; stream_dest = 4'hE;
      cyc();
    end
    start = 1'b0;
    wait_idle();

    // start in the done cycle is accepted immediately.
    issue(8'd3, 32'd50, 8'd6, 4'd6);
    n = 0;
    while (!done && n < 100) begin cyc(); n++; end
    chk("done_seen", 64'(done), 64'd1);
    issue(8'd2, 32'd60, 8'd7, 4'd7);
    wait_idle();
    chk("count_directed", 64'(pkt_count), 64'(model_pkts));

    // Randomized packets.
    for (int k = 0; k < 20; k++) begin
      rmode = 1'($urandom_range(0, 1));
      issue(8'($urandom_range(0, 14)), $urandom, 8'($urandom), 4'($urandom));
      wait_idle();
    end
    chk("count_final", 64'(pkt_count), 64'(model_pkts));
    chk("queue_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
